// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// One frame bit per clk; tx_out and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Handshake: a word is accepted on any posedge where state is IDLE and
  // data_valid is 1; there is no ready output, busy=0 means the next edge can accept.
  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  par_bit;
  logic                  par_bit_next;
  logic                  par_en_q;
  logic                  par_en_next;
  logic                  tx_next;
  logic                  busy_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      par_en_q  <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      par_bit   <= par_bit_next;
      par_en_q  <= par_en_next;
      tx_out    <= tx_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    cnt_next     = bit_cnt;
    par_bit_next = par_bit;
    par_en_next  = par_en_q;
    tx_next      = 1'b1;
    busy_next    = 1'b1;

    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next   = START;
          shift_next   = p_data;
          par_bit_next = (^p_data) ^ par_typ;
          par_en_next  = par_en;
        end
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = par_en_q ? PARITY : STOP;
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops show the bit of the state being entered.
    case (state_next)
      IDLE:  busy_next = 1'b0;
      START: tx_next   = 1'b0;
      DATA: begin
        tx_next    = shift_reg[0];
        shift_next = shift_reg >> 1;
      end
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus hand-written reset,
// back-to-back and mid-frame-reset sequences.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bits are written first-bit-leftmost; bit (len-1-i) is frame bit i.
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int          len;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_tx"}, tx_out, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Accept a word at the next posedge, then drop data_valid.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  // Checks every frame bit and the idle cycle after it; optionally disturbs inputs mid-frame.
  task automatic run_frame(input logic [10:0] exp, input int len, input bit disturb);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("bit%0d_tx", i), tx_out, exp[len-1-i]);
      check($sformatf("bit%0d_busy", i), busy, 1'b1);
      if (disturb) begin
        if (i == 0) begin
          p_data  = ~p_data;
          par_en  = ~par_en;
          par_typ = ~par_typ;
        end
        if (i == 3) data_valid = 1'b1;
        if (i == 4) data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("after_frame");
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b00101001011};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 11, 11'b01000000001};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 11, 11'b00000000001};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 11, 11'b01111111111};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 11, 11'b00000000111};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 11, 11'b01110000001};
    vecs[7] = '{8'h3C, 1'b0, 1'b1, 10, 11'b00001111001};

    rst        = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;

    // Reset held, then a long idle stretch.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("in_reset");
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Table of single frames, each with input changes and a stray request mid-frame.
    foreach (vecs[v]) begin
      start_frame(vecs[v].data, vecs[v].pe, vecs[v].pt);
      run_frame(vecs[v].exp, vecs[v].len, 1'b1);
    end

    // Level data_valid: frames repeat every 11 cycles with one idle bit between.
    @(negedge clk);
    p_data     = 8'h3C;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        if (i < 10) begin
          check($sformatf("b2b_f%0d_bit%0d", f, i), tx_out, vecs[7].exp[9-i]);
          check($sformatf("b2b_f%0d_busy%0d", f, i), busy, 1'b1);
        end else begin
          check_idle($sformatf("b2b_gap%0d", f));
        end
        if (f == 1 && i == 4) p_data = 8'hFF;
        if (f == 1 && i == 5) p_data = 8'h3C;
        if (f == 2 && i == 10) data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("b2b_end");

    // Reset during data bit 4 of 0x00; outputs must return to idle without a clock.
    start_frame(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("pre_rst_bit%0d", i), tx_out, 1'b0);
      check($sformatf("pre_rst_busy%0d", i), busy, 1'b1);
    end
    #2 rst = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    check_idle("rst_hold");
    // Request present in the same cycle reset releases.
    rst        = 1'b1;
    p_data     = 8'h55;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    run_frame(11'b00101010101, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the UART_RX path (start check, sampling, deserializer).
- Accepts one parallel word per handshake and serializes it on tx_out as: start bit, data LSB first, optional parity bit, stop bit.
- One frame bit per clk cycle; clk is the TX baud clock, produced by the system clock divider.
- Sits between the system-side TX FIFO reader and the UART pad.

Parameters:
- DATA_WIDTH, 8, width of the payload word (valid range 5..9).

Ports:
- clk  input  1  TX baud clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  parallel word to transmit; captured only on acceptance.
- data_valid  input  1  request to send p_data; single-cycle pulse or level.
- par_en  input  1  1 = insert parity bit; captured on acceptance.
- par_typ  input  1  0 = even parity, 1 = odd parity; captured on acceptance.
- tx_out  output  1  serial line, registered; idle level 1.
- busy  output  1  registered; 1 while a frame is on the line.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, tx_out=1, busy=0, shift register cleared, bit counter 0, latched parity config 0.
- FSM states are IDLE, START, DATA, PARITY and STOP, with these transitions:
  - IDLE: tx_out=1, busy=0. data_valid=1 at a posedge: capture p_data, par_en, par_typ and compute the parity bit at that edge, then go to START.
  - START: tx_out=0, busy=1. Go to DATA.
  - DATA: tx_out=current LSB of the shift register; shift right each cycle. After DATA_WIDTH cycles go to PARITY if the latched par_en=1, otherwise to STOP.
  - PARITY: tx_out=parity bit. Go to STOP.
  - STOP: tx_out=1, busy=1. Go to IDLE.
- tx_out and busy are driven from registers, with no combinational path from inputs.
- Latency: if data_valid is sampled high at edge k in IDLE, the start bit appears on tx_out after edge k, and busy rises after edge k.
- Data bit i is on tx_out after edge k+1+i.
- Frame length, with busy high for exactly this many cycles:
  - DATA_WIDTH+2 cycles when par_en=0.
  - DATA_WIDTH+3 cycles when par_en=1.
- Parity bit:
  - Even: XOR-reduction of the captured word.
  - Odd: inverted XOR-reduction.
  - Computed from the captured word, not the live p_data.
- data_valid is ignored whenever state is not IDLE. It is neither queued nor counted.
- p_data, par_en and par_typ changes during a frame have no effect on the frame in progress.
- Minimum inter-frame gap: one idle cycle, because STOP always returns to IDLE before the next acceptance.
- A level-high data_valid therefore produces back-to-back frames separated by exactly one idle-high bit.
- Bit counter: width ceil(log2(DATA_WIDTH+1)). It resets to 0 on entry to DATA and never wraps within a frame.
- Reset asserted mid-frame: tx_out forced to 1 and busy to 0 immediately, without waiting for a clock. The partial frame is abandoned. After rst deasserts, the block waits in IDLE for a new data_valid.
- data_valid high in the same cycle rst deasserts: accepted at the first posedge with rst high.
- Undriven or X inputs never reach tx_out while in IDLE.

Test Plan:
- Reset then idle: hold rst low 3 cycles, release, data_valid=0 for 20 cycles -> tx_out=1 and busy=0 throughout.
- No parity: p_data=0xA5, par_en=0, data_valid pulse -> tx_out sequence 0,1,0,1,0,0,1,0,1,1; busy high 10 cycles, then 0.
- Even parity: p_data=0xA5, par_en=1, par_typ=0 -> sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0); busy high 11 cycles.
- Odd parity and capture:
  - Stimulus: p_data=0x01, par_en=1, par_typ=1; change p_data to 0xFF one cycle after acceptance.
  - Response: sequence 0,1,0,0,0,0,0,0,0,0,1 (parity 0 for one set bit, odd); the 0xFF change has no effect.
- Back-to-back and ignored request:
  - Hold data_valid high with p_data=0x3C, no parity. Response: frames repeat every 11 cycles (10 frame bits plus 1 idle).
  - Pulse data_valid with p_data=0xFF mid-frame. Response: no change to the current frame.
- Mid-frame reset: assert rst during data bit 4 of 0x00 -> tx_out=1 and busy=0 within the same cycle. After release, a new 0x55 frame is sent correctly: 0,1,0,1,0,1,0,1,0,1.
